// File: rtl/result_bcd_formatter.sv
// Result-to-BCD formatter: captures one 8-bit colour channel of the core result,
// converts it to three decimal digits with a sequential double-dabble engine and
// presents the channel indicator plus hundreds/tens/ones to the display driver.
// Digit outputs only change at the end of a conversion, so the display never
// shows a partially converted value.
module result_bcd_formatter #(
  parameter logic [4:0] BLANK_CODE = 5'h1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] result,
  input  logic [1:0]  ch_sel,
  input  logic        blank_en,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  mi_digit,
  output logic [4:0]  hundreds,
  output logic [4:0]  tens,
  output logic [4:0]  ones
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFormat
  } state_e;

  localparam logic [1:0] ChInvalid = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;       // remaining binary bits, shifted out MSB first
  logic [11:0] bcd_q, bcd_d;     // {hundreds, tens, ones} nibbles
  logic [2:0]  cnt_q, cnt_d;     // shift iteration index
  logic [1:0]  ch_q, ch_d;       // channel latched at start
  logic        blank_q, blank_d; // blanking enable latched at start
  logic        done_q, done_d;
  logic [4:0]  mi_q, mi_d;
  logic [4:0]  hun_q, hun_d;
  logic [4:0]  ten_q, ten_d;
  logic [4:0]  one_q, one_d;

  logic [7:0]  chan_val;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic [4:0]  fmt_mi, fmt_hun, fmt_ten, fmt_one;

  // Add 3 to every BCD nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [11:0] add3_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Select the requested colour channel; the invalid selection converts zero
  // and is blanked at format time anyway.
  always_comb begin
    chan_val = 8'h00;
    unique case (ch_sel)
      2'd0:    chan_val = result[23:16];
      2'd1:    chan_val = result[15:8];
      2'd2:    chan_val = result[7:0];
      default: chan_val = 8'h00;
    endcase
  end

  // One double-dabble iteration: adjust, then shift {bcd, operand} left by one.
  always_comb begin
    bcd_adj = add3_adjust(bcd_q);
    shifted = {bcd_adj, op_q} << 1;
  end

  // Digit encoding with optional leading-zero blanking and invalid-channel blanking.
  always_comb begin
    fmt_mi  = {3'b000, ch_q} + 5'd1;
    fmt_hun = {1'b0, bcd_q[11:8]};
    fmt_ten = {1'b0, bcd_q[7:4]};
    fmt_one = {1'b0, bcd_q[3:0]};
    if (blank_q) begin
      if (bcd_q[11:8] == 4'd0) begin
        fmt_hun = BLANK_CODE;
      end
      if (bcd_q[11:4] == 8'd0) begin
        fmt_ten = BLANK_CODE;
      end
    end
    if (ch_q == ChInvalid) begin
      fmt_mi  = BLANK_CODE;
      fmt_hun = BLANK_CODE;
      fmt_ten = BLANK_CODE;
      fmt_one = BLANK_CODE;
    end
  end

  // Next-state logic for the IDLE -> SHIFT x8 -> FORMAT sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    mi_d    = mi_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = chan_val;
          ch_d    = ch_sel;
          blank_d = blank_en;
          bcd_d   = 12'd0;
          cnt_d   = 3'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = shifted[19:8];
        op_d  = shifted[7:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StFormat;
        end
      end
      StFormat: begin
        mi_d    = fmt_mi;
        hun_d   = fmt_hun;
        ten_d   = fmt_ten;
        one_d   = fmt_one;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous reset takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 8'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 3'd0;
      ch_q    <= 2'd0;
      blank_q <= 1'b0;
      done_q  <= 1'b0;
      mi_q    <= BLANK_CODE;
      hun_q   <= BLANK_CODE;
      ten_q   <= BLANK_CODE;
      one_q   <= BLANK_CODE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      blank_q <= blank_d;
      done_q  <= done_d;
      mi_q    <= mi_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign mi_digit = mi_q;
  assign hundreds = hun_q;
  assign tens     = ten_q;
  assign ones     = one_q;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Scoreboard bench for result_bcd_formatter: the driver predicts each accepted
// conversion with a divide/modulo model and queues it; a negedge monitor pops
// entries when the DUT reports done and checks busy, done and the digit outputs.
module tb_result_bcd_formatter;

  localparam logic [4:0] Blank = 5'h1F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] result = 24'd0;
  logic [1:0]  ch_sel = 2'd0;
  logic        blank_en = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  mi_digit, hundreds, tens, ones;

  result_bcd_formatter #(
    .BLANK_CODE(Blank)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .result   (result),
    .ch_sel   (ch_sel),
    .blank_en (blank_en),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mi_digit (mi_digit),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] mi;
    logic [4:0] h;
    logic [4:0] t;
    logic [4:0] o;
  } digits_t;

  typedef struct packed {
    int      cyc;
    digits_t d;
  } exp_t;

  exp_t    q[$];
  int      edge_n = 0;
  int      last_e = -100;
  int      rst_edge = -1;
  bit      mon_en = 1'b0;
  int      n_checks = 0;
  int      n_err = 0;
  digits_t disp = '{Blank, Blank, Blank, Blank};
  bit      exp_done;
  exp_t    e;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Decimal digits of the selected channel, straight from the display rules.
  function automatic digits_t ref_digits(input logic [23:0] res, input logic [1:0] ch,
                                         input logic bl);
    digits_t d;
    int v;
    if (ch == 2'd3) return '{Blank, Blank, Blank, Blank};
    v = int'((res >> (8 * (2 - int'(ch)))) & 24'hFF);
    d.mi = 5'(int'(ch) + 1);
    d.h  = 5'(v / 100);
    d.t  = 5'((v / 10) % 10);
    d.o  = 5'(v % 10);
    if (bl && v < 100) d.h = Blank;
    if (bl && v < 10)  d.t = Blank;
    return d;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, want, edge_n);
    end
  endtask

  // Drive one clock edge and record what the model says that edge does.
  task automatic step(input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    #1;
    if (r) begin
      rst_edge = edge_n;
      last_e   = -100;
    end else if (s && edge_n >= last_e + 10) begin
      last_e = edge_n;
      q.push_back('{cyc: edge_n + 9, d: ref_digits(result, ch_sel, blank_en)});
    end
  endtask

  task automatic noise();
    result   = 24'($urandom);
    ch_sel   = 2'($urandom_range(0, 3));
    blank_en = 1'($urandom_range(0, 1));
  endtask

  task automatic conv(input logic [23:0] res, input logic [1:0] ch, input logic bl);
    result   = res;
    ch_sel   = ch;
    blank_en = bl;
    step(1'b1, 1'b0);
    repeat (10) begin
      noise();
      step(1'b0, 1'b0);
    end
  endtask

  // Monitor: compare every cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (edge_n == rst_edge) begin
        q.delete();
        disp = '{Blank, Blank, Blank, Blank};
      end
      exp_done = (q.size() > 0) && (q[0].cyc == edge_n);
      chk("done", int'(done), int'(exp_done));
      if (q.size() > 0 && (done || q[0].cyc <= edge_n)) begin
        e = q.pop_front();
        disp = e.d;
      end
      chk("busy", int'(busy), int'(edge_n >= last_e && edge_n <= last_e + 8));
      chk("mi_digit", int'(mi_digit), int'(disp.mi));
      chk("hundreds", int'(hundreds), int'(disp.h));
      chk("tens", int'(tens), int'(disp.t));
      chk("ones", int'(ones), int'(disp.o));
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b0);

    // Directed cases, including blanking and the invalid channel.
    conv(24'hFF0000, 2'd0, 1'b0);
    conv(24'h000064, 2'd2, 1'b1);
    conv(24'h000007, 2'd2, 1'b1);
    conv(24'h000000, 2'd2, 1'b1);
    conv(24'h002A00, 2'd1, 1'b1);
    conv(24'h002A00, 2'd1, 1'b0);
    conv(24'h123456, 2'd3, 1'b1);
    conv(24'hFFFFFF, 2'd3, 1'b0);

    // Second start during a conversion is ignored; result changes mid-flight.
    result = 24'h00C800; ch_sel = 2'd1; blank_en = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    result = 24'h000500; ch_sel = 2'd0;
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Reset at E4 of a conversion, then a quiet window.
    result = 24'h00FE00; ch_sel = 2'd1; blank_en = 1'b0;
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // Reset and start on the same edge.
    result = 24'h7B0000; ch_sel = 2'd0;
    step(1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b0);

    // Start held high: back-to-back conversions every 10 clocks.
    repeat (45) begin
      noise();
      step(1'b1, 1'b0);
    end
    repeat (10) step(1'b0, 1'b0);

    // Exhaustive sweep of every value on every channel.
    for (int c = 0; c < 3; c++) begin
      for (int v = 0; v < 256; v++) begin
        result = 24'($urandom);
        result[8 * (2 - c) +: 8] = 8'(v);
        ch_sel = 2'(c);
        blank_en = 1'($urandom_range(0, 1));
        step(1'b1, 1'b0);
        repeat (9) begin
          noise();
          step(1'b0, 1'b0);
        end
      end
    end

    // Random start/reset traffic.
    repeat (1500) begin
      noise();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (15) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/result_bcd_formatter.md
# result_bcd_formatter

Downstream stage of the image processor core. Captures the 24-bit `result` word on request, selects one 8-bit colour channel, and converts it to three decimal digits with a sequential shift-and-add-3 (double-dabble) engine. It drives the four low digit inputs of the seven-segment display: a channel indicator, hundreds, tens and ones. The outputs update atomically at the end of each conversion, so the display never shows a partially converted value.

## Interface
Parameters:
- `BLANK_CODE`, default 5'h1F: digit code that the seven-segment driver renders as blank.

Ports:
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset. Synchronous and active-high.
- `result` input 24: core output. Bits [23:16] are R, [15:8] are G, [7:0] are B.
- `ch_sel` input 2: channel select. 0 selects R, 1 selects G, 2 selects B, 3 is invalid.
- `blank_en` input 1: enables leading-zero blanking.
- `start` input 1: conversion request. Sampled only in IDLE.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when new digits are valid.
- `mi_digit` output 5: channel indicator digit, fed to dig3.
- `hundreds` output 5: fed to dig2.
- `tens` output 5: fed to dig1.
- `ones` output 5: fed to dig0.

## Operation
- State machine states: IDLE, SHIFT, FORMAT.
- **IDLE**
  - When `start`=1: latch `result[ch]` into an 8-bit shift operand, latch `ch_sel` and `blank_en`, clear the 12-bit BCD accumulator and the 3-bit counter, then go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**, one iteration per cycle, 8 cycles in total:
  - First, add 3 to each BCD nibble that is ≥5.
  - Then shift {bcd, operand} left by 1.
  - After the 8th iteration (counter = 7), go to FORMAT.
- **FORMAT**, one cycle: register the outputs, pulse `done`, return to IDLE.
- Output encoding:
  - `mi_digit` = `ch_sel`+1, so R, G and B show as 1, 2, 3.
  - Each digit output is {1'b0, nibble}.
- Leading-zero blanking, applied only when the latched `blank_en`=1:
  - If the hundreds nibble is 0, `hundreds` = BLANK_CODE.
  - If the hundreds and tens nibbles are both 0, `tens` = BLANK_CODE.
  - `ones` is never blanked.
- Invalid channel (`ch_sel`=3): the full conversion still runs. In FORMAT, all four digits are set to BLANK_CODE and `done` still pulses.
- `start` is ignored while `busy`=1. It is not queued.
- `result` and `ch_sel` may change during a conversion. Only the values latched in IDLE are used.
- Arithmetic: the maximum input is 255, so the hundreds nibble never exceeds 2 and no overflow is possible.

## Timing
- Edge E0 samples `start` in IDLE. Edges E1–E8 perform the shifts. E9 executes FORMAT.
- `busy` is high in the cycles after E0 through the cycle after E8. `busy` = (state != IDLE).
- `done` is high for exactly the one cycle after E9. New digit values appear in that same cycle.
- Start-to-done latency: 9 clocks. Maximum throughput: one conversion per 10 clocks.
- Back-to-back operation: `start` held high continuously causes a new conversion on the edge after the `done` cycle's edge. The FSM is in IDLE while `done` is high, so `start` sampled in that cycle is accepted.
- Digit outputs hold their values between `done` pulses.
- Reset values: `busy`=0, `done`=0, and `mi_digit`, `hundreds`, `tens`, `ones` all = BLANK_CODE. State is IDLE and the counter is 0.
- Reset mid-conversion: the next edge forces reset values. No `done` is produced and no partial digits reach the outputs.
- `rst` and `start` both high on the same edge: reset wins.

## Test plan
- R: `result`=24'hFF0000, `ch_sel`=0, `blank_en`=0, pulse `start` → exactly 9 clocks later `done`=1 and the digits are 1,2,5,5.
- B: `result`=24'h000064, `ch_sel`=2, `blank_en`=1 → digits 3,1,0,0. Repeat with 8'h07 → 3,1F,1F,7. Repeat with 8'h00 → 3,1F,1F,0.
- G: `result`=24'h00_2A_00 (value 42), `blank_en`=1 → digits 2,1F,4,2. Exhaustive sweep of 0–255 on each channel compared against a reference divide/modulo model.
- Pulse `start` at E0 and again at E3 while changing `result`. → Exactly one `done`, at E9, carrying the E0 value. `busy` is high for 9 cycles.
- Assert `rst` at E4 of a conversion → the next cycle shows `busy`=0 and all digits 1F. No `done` occurs during the following 20 cycles.
- `ch_sel`=3 → `done` after 9 clocks with all four digits 1F. `start` held high → `done` pulses every 10 clocks.
